// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - RV64 load/store unit with read-modify-write for sub-doubleword stores
//
// Sits between the EX/MEM pipeline register and a 64-bit word-addressed data
// memory. Loads pick a byte lane and extend it. SD writes in one cycle. SB/SH/SW
// read the doubleword, stall one cycle, then write the merged word back.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/req_we   operation present / 1 = store
//   req_funct3         RV64 size and signedness
//   req_addr           byte address
//   req_wdata          right-aligned store data
//   stall              combinational upstream hold for this cycle
//   mem_a/mem_wd/mem_we  doubleword index, write data, write enable to memory
//   mem_rd             combinational read data at mem_a
//   load_data/load_valid  registered load result and its one-cycle strobe
//   access_fault       registered one-cycle fault strobe

module lsu_rmw #(
    parameter int DEPTH = 1024,
    parameter int IDXW  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        stall,
    output logic [63:0] mem_a,
    output logic [63:0] mem_wd,
    output logic        mem_we,
    input  logic [63:0] mem_rd,
    output logic [63:0] load_data,
    output logic        load_valid,
    output logic        access_fault
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state_q;
    logic [63:0]       load_data_q;
    logic              load_valid_q;
    logic              fault_q;

    // Context latched on the accept cycle of a sub-doubleword store.
    logic [63:0]       rd_q;
    logic [63:0]       wdata_q;
    logic [IDXW-1:0]   idx_q;
    logic [2:0]        off_q;
    logic [1:0]        size_q;

    logic [2:0]        off;
    logic [IDXW-1:0]   idx;
    logic              misaligned;
    logic              out_of_range;
    logic              illegal;
    logic              fault;
    logic              accept;
    logic              is_sd;
    logic              is_rmw;
    logic [63:0]       lane;
    logic [63:0]       load_data_d;
    logic [7:0]        byte_en;
    logic [63:0]       bit_mask;
    logic [63:0]       wdata_sh;
    logic [63:0]       merged;

    assign off = req_addr[2:0];
    assign idx = req_addr[IDXW+2:3];

    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off[1:0] != 2'b00);
            2'b11:   misaligned = (off != 3'b000);
            default: misaligned = 1'b0;
        endcase
    end

    assign out_of_range = (req_addr[63:3] >= 61'(DEPTH));
    assign illegal      = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    assign fault        = misaligned | out_of_range | illegal;
    assign accept       = (state_q == IDLE) && req_valid && !fault;
    assign is_sd        = req_we && (req_funct3 == 3'b011);
    // Only reached when not faulting, so funct3[2] is already known to be 0.
    assign is_rmw       = req_we && (req_funct3[1:0] != 2'b11);

    // Load path: move the addressed lane down to bit 0, then extend.
    assign lane = mem_rd >> {off, 3'b000};

    always_comb begin
        load_data_d = lane;
        case (req_funct3)
            3'b000:  load_data_d = {{56{lane[7]}},  lane[7:0]};
            3'b001:  load_data_d = {{48{lane[15]}}, lane[15:0]};
            3'b010:  load_data_d = {{32{lane[31]}}, lane[31:0]};
            3'b100:  load_data_d = {56'd0, lane[7:0]};
            3'b101:  load_data_d = {48'd0, lane[15:0]};
            3'b110:  load_data_d = {32'd0, lane[31:0]};
            default: load_data_d = lane;
        endcase
    end

    // Merge path: byte enables for the store size, shifted to the offset.
    // Alignment was enforced at accept, so the shift never spills past byte 7.
    always_comb begin
        case (size_q)
            2'b00:   byte_en = 8'h01;
            2'b01:   byte_en = 8'h03;
            2'b10:   byte_en = 8'h0F;
            default: byte_en = 8'hFF;
        endcase
        byte_en = byte_en << off_q;
        bit_mask = '0;
        for (int k = 0; k < 8; k++) begin
            bit_mask[8*k +: 8] = {8{byte_en[k]}};
        end
    end

    assign wdata_sh = wdata_q << {off_q, 3'b000};
    assign merged   = (rd_q & ~bit_mask) | (wdata_sh & bit_mask);

    always_comb begin
        mem_a = '0;
        mem_a[IDXW-1:0] = (state_q == WRITE) ? idx_q : idx;
    end

    assign mem_wd = (state_q == WRITE) ? merged : req_wdata;
    // rst gates the strobes so a reset landing on WRITE drops the partial store.
    assign mem_we = !rst && ((state_q == WRITE) || (accept && is_sd));
    assign stall  = !rst && accept && is_rmw;

    assign load_data    = load_data_q;
    assign load_valid   = load_valid_q;
    assign access_fault = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (fault) begin
                            fault_q <= 1'b1;
                        end else if (!req_we) begin
                            load_data_q  <= load_data_d;
                            load_valid_q <= 1'b1;
                        end else if (is_rmw) begin
                            rd_q    <= mem_rd;
                            wdata_q <= req_wdata;
                            idx_q   <= idx;
                            off_q   <= off;
                            size_q  <= req_funct3[1:0];
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// tb/tb_lsu_rmw.sv - randomized self-checking bench for lsu_rmw against a byte-level reference model

module tb_lsu_rmw;

    localparam int DEPTH = 1024;
    localparam int IDXW  = 10;
    localparam int NWORDS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        stall;
    logic [63:0] mem_a;
    logic [63:0] mem_wd;
    logic        mem_we;
    logic [63:0] mem_rd;
    logic [63:0] load_data;
    logic        load_valid;
    logic        access_fault;

    logic [63:0] mem [0:DEPTH-1];
    logic [63:0] ref_mem [0:DEPTH-1];
    logic        bk_we;
    logic [IDXW-1:0] bk_idx;
    logic [63:0] bk_data;
    logic [63:0] last_load;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lsu_rmw #(.DEPTH(DEPTH), .IDXW(IDXW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .mem_a       (mem_a),
        .mem_wd      (mem_wd),
        .mem_we      (mem_we),
        .mem_rd      (mem_rd),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .access_fault(access_fault)
    );

    assign mem_rd = mem[mem_a[IDXW-1:0]];

    always @(posedge clk) begin
        if (mem_we)     mem[mem_a[IDXW-1:0]] <= mem_wd;
        else if (bk_we) mem[bk_idx] <= bk_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic model_fault(input logic we, input logic [2:0] f3, input logic [63:0] addr);
        int nb;
        logic mis, oor, ill;
        nb  = 1 << f3[1:0];
        mis = (int'(addr[2:0]) % nb) != 0;
        oor = (addr >> 3) >= 64'(DEPTH);
        ill = we ? (f3 >= 3'd4) : (f3 == 3'd7);
        return mis || oor || ill;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] word, input logic [2:0] f3, input logic [2:0] off);
        int nb;
        logic [63:0] v;
        nb = 1 << f3[1:0];
        v  = '0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = word[8*(int'(off)+k) +: 8];
        if (!f3[2] && nb < 8 && v[8*nb-1])
            for (int k = nb; k < 8; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [63:0] model_store(input logic [63:0] word, input logic [2:0] f3,
                                                input logic [2:0] off, input logic [63:0] wd);
        int nb;
        logic [63:0] w;
        nb = 1 << f3[1:0];
        w  = word;
        for (int k = 0; k < nb; k++) w[8*(int'(off)+k) +: 8] = wd[8*k +: 8];
        return w;
    endfunction

    task automatic poke(input int i, input logic [63:0] d);
        req_valid = 1'b0;
        bk_we   = 1'b1;
        bk_idx  = IDXW'(i);
        bk_data = d;
        @(posedge clk); #1;
        bk_we = 1'b0;
        ref_mem[i] = d;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(negedge clk);
        check("idle_stall", stall, 1'b0);
        check("idle_mem_we", mem_we, 1'b0);
        @(posedge clk); #1;
        check("idle_load_valid", load_valid, 1'b0);
        check("idle_fault", access_fault, 1'b0);
        check("idle_load_data", load_data, last_load);
    endtask

    task automatic op(input logic we, input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wd);
        logic flt, sd_ok, rmw;
        logic [2:0] off;
        logic [IDXW-1:0] idx;
        logic [63:0] nw, ld;
        flt   = model_fault(we, f3, addr);
        off   = addr[2:0];
        idx   = addr[IDXW+2:3];
        sd_ok = !flt && we && f3 == 3'd3;
        rmw   = !flt && we && f3 < 3'd3;
        nw    = model_store(ref_mem[idx], f3, off, wd);
        ld    = model_load(ref_mem[idx], f3, off);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        check("stall", stall, rmw);
        check("mem_we", mem_we, sd_ok);
        if (!flt) check("mem_a", mem_a, 64'(idx));
        if (sd_ok) check("sd_mem_wd", mem_wd, wd);
        @(posedge clk); #1;
        if (rmw) begin
            @(negedge clk);
            check("wr_stall", stall, 1'b0);
            check("wr_mem_we", mem_we, 1'b1);
            check("wr_mem_a", mem_a, 64'(idx));
            check("wr_mem_wd", mem_wd, nw);
            @(posedge clk); #1;
        end
        if (!flt && we) ref_mem[idx] = nw;
        if (!flt && !we) last_load = ld;
        check("load_valid", load_valid, !flt && !we);
        check("access_fault", access_fault, flt);
        check("load_data", load_data, last_load);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic we;
        logic [2:0] f3;
        logic [63:0] addr;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; bk_we = 1'b0; bk_idx = '0; bk_data = '0;
        last_load = '0;
        for (int i = 0; i < NWORDS; i++) poke(i, 64'd0);

        // SD presented during reset must not write or stall.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd3; req_addr = 64'h8; req_wdata = 64'h55;
        @(negedge clk);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_stall", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        check("rst_load_data", load_data, 64'd0);
        check("rst_load_valid", load_valid, 1'b0);
        check("rst_fault", access_fault, 1'b0);
        idle();

        // Byte loads, signed and unsigned.
        poke(2, 64'h8877_6655_4433_2281);
        op(1'b0, 3'b000, 64'h10, 64'd0);
        op(1'b0, 3'b100, 64'h10, 64'd0);
        idle();

        // SB read-modify-write then read back.
        poke(1, 64'h1111_2222_3333_4444);
        op(1'b1, 3'b000, 64'h0B, 64'hAB);
        op(1'b0, 3'b011, 64'h08, 64'd0);

        // SW into zeroed word, SD single cycle.
        poke(2, 64'd0);
        op(1'b1, 3'b010, 64'h14, 64'hDEAD_BEEF);
        op(1'b0, 3'b011, 64'h10, 64'd0);
        op(1'b1, 3'b011, 64'h18, 64'h0123_4567_89AB_CDEF);
        op(1'b0, 3'b011, 64'h18, 64'd0);

        // Faults.
        op(1'b0, 3'b010, 64'h06, 64'd0);
        op(1'b1, 3'b001, 64'h03, 64'hFFFF);
        op(1'b0, 3'b011, 64'h2000, 64'd0);
        op(1'b0, 3'b111, 64'h10, 64'd0);
        op(1'b1, 3'b100, 64'h10, 64'd0);
        idle();

        // Reset landing on the WRITE cycle of an SB.
        poke(3, 64'hCAFE_F00D_1234_5678);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 64'h1A; req_wdata = 64'h99;
        @(negedge clk);
        check("rmw_rst_accept_stall", stall, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rmw_rst_mem_we", mem_we, 1'b0);
        check("rmw_rst_stall", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        last_load = '0;
        check("rmw_rst_load_data", load_data, last_load);
        check("rmw_rst_word", mem[3], ref_mem[3]);
        op(1'b0, 3'b011, 64'h18, 64'd0);

        // Back-to-back with req_valid held: SH, LHU, SD, LW.
        op(1'b1, 3'b001, 64'h22, 64'h1234_BEEF);
        op(1'b0, 3'b101, 64'h22, 64'd0);
        op(1'b1, 3'b011, 64'h28, 64'hA5A5_5A5A_0F0F_F0F0);
        op(1'b0, 3'b010, 64'h20, 64'd0);
        idle();

        // Randomized traffic over the first NWORDS doublewords.
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            if (we) f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            else    f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0)
                addr = {$urandom, $urandom} | 64'h2000;
            else if ($urandom_range(0, 3) == 0)
                addr = 64'($urandom_range(0, NWORDS*8-1));
            else
                addr = 64'($urandom_range(0, NWORDS-1) * 8 + ($urandom_range(0, 7) & ~((1 << f3[1:0]) - 1)));
            op(we, f3, addr, {$urandom, $urandom});
            if ($urandom_range(0, 4) == 0) idle();
        end
        idle();

        for (int i = 0; i < NWORDS; i++) check($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
